// File: rtl/wb_pkg.sv
// Shared widths, defaults and FSM state encoding for the two-master Wishbone arbiter.
package wb_pkg;

  localparam int ADR_WIDTH_DEF = 24;
  localparam int DAT_WIDTH_DEF = 16;
  localparam int TIMEOUT_DEF   = 255;
  localparam int TMO_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus watchdog: counts unacknowledged strobe cycles and emits a one-cycle error pulse
// on the last permitted cycle, then restarts so a retrying master gets a fresh window.
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ack_i,
  output logic err_pulse_o
);

  localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  // An ACK landing in the terminal cycle suppresses the error.
  assign err_pulse_o = active_i & ~ack_i & (cnt_q == LAST);

  always_comb begin
    if (!active_i || ack_i || err_pulse_o) cnt_d = '0;
    else                                   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// Round-robin arbiter sharing one Wishbone classic slave between two masters,
// with per-tenure grants and a watchdog that converts a hung slave into ERR.
module wishbone_arbiter_2m
  import wb_pkg::*;
#(
  parameter int ADR_WIDTH      = ADR_WIDTH_DEF,
  parameter int DAT_WIDTH      = DAT_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADR_WIDTH-1:0] m0AdrI,
  input  logic [DAT_WIDTH-1:0] m0DatI,
  output logic [DAT_WIDTH-1:0] m0DatO,
  input  logic                 m0CycI,
  input  logic                 m0StbI,
  input  logic                 m0WeI,
  output logic                 m0AckO,
  output logic                 m0ErrO,
  input  logic [ADR_WIDTH-1:0] m1AdrI,
  input  logic [DAT_WIDTH-1:0] m1DatI,
  output logic [DAT_WIDTH-1:0] m1DatO,
  input  logic                 m1CycI,
  input  logic                 m1StbI,
  input  logic                 m1WeI,
  output logic                 m1AckO,
  output logic                 m1ErrO,
  output logic [ADR_WIDTH-1:0] wbAdrO,
  output logic [DAT_WIDTH-1:0] wbDatO,
  input  logic [DAT_WIDTH-1:0] wbDatI,
  output logic                 wbCycO,
  output logic                 wbStbO,
  output logic                 wbWeO,
  input  logic                 wbAckI,
  output logic [1:0]           grantO
);

  state_e     state_q;
  logic [1:0] grant_q;
  logic       last_q;

  logic own0, own1;
  logic own_cyc, own_stb;
  logic err_pulse;

  // A tenure always returns through IDLE, which guarantees the idle gap between owners.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (m0CycI && (!m1CycI || last_q)) begin
            state_q <= ST_OWN0;
            grant_q <= 2'b01;
          end else if (m1CycI) begin
            state_q <= ST_OWN1;
            grant_q <= 2'b10;
          end
        end
        ST_OWN0: begin
          if (!m0CycI) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b0;
          end
        end
        ST_OWN1: begin
          if (!m1CycI) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign own0   = grant_q[0];
  assign own1   = grant_q[1];
  assign grantO = grant_q;

  always_comb begin
    wbAdrO  = '0;
    wbDatO  = '0;
    wbWeO   = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (own0) begin
      wbAdrO  = m0AdrI;
      wbDatO  = m0DatI;
      wbWeO   = m0WeI;
      own_cyc = m0CycI;
      own_stb = m0StbI;
    end else if (own1) begin
      wbAdrO  = m1AdrI;
      wbDatO  = m1DatI;
      wbWeO   = m1WeI;
      own_cyc = m1CycI;
      own_stb = m1StbI;
    end
  end

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .active_i   (own_cyc & own_stb),
    .ack_i      (wbAckI),
    .err_pulse_o(err_pulse)
  );

  // STB without CYC from the owner never reaches the slave.
  assign wbCycO = own_cyc;
  assign wbStbO = own_cyc & own_stb & ~err_pulse;

  assign m0AckO = own0 & wbAckI;
  assign m1AckO = own1 & wbAckI;
  assign m0ErrO = own0 & err_pulse;
  assign m1ErrO = own1 & err_pulse;
  assign m0DatO = own0 ? wbDatI : '0;
  assign m1DatO = own1 ? wbDatI : '0;

endmodule
